// File: rtl/fxmul_pkg.sv
// Shared types, defaults and the saturation helper for the sequential sign-magnitude multiplier.
// The FXMUL_ROUND_EN build option lives in fxmul_norm and fxmul_seq; nothing here depends on it.
package fxmul_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fxmul_state_t;

  localparam int unsigned FXMUL_W_DEF = 16;
  localparam int unsigned FXMUL_F_DEF = 8;

  // Fixed working width for sm_sat; covers W up to 32 even with the rounding guard bit.
  localparam int unsigned SAT_W = 64;

  // Returns {overflow, magnitude}; the magnitude is right-justified and clamped to mag_w bits.
  function automatic logic [SAT_W:0] sm_sat(input logic [SAT_W-1:0] s, input int unsigned mag_w);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << mag_w) - SAT_W'(1);
    if (s > lim) return {1'b1, lim};
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/fxmul_norm.sv
// Combinational scale/saturate/flag stage: turns {sign, product accumulator} into a W-bit result.
// With FXMUL_ROUND_EN defined it rounds half-up before the shift instead of truncating.
module fxmul_norm
  import fxmul_pkg::*;
#(
  parameter int unsigned W     = FXMUL_W_DEF,
  parameter int unsigned F     = FXMUL_F_DEF,
  parameter int unsigned ACC_W = 2 * (W - 1)
) (
  input  logic             i_sign,
  input  logic [ACC_W-1:0] i_acc,
  output logic [W-1:0]     o_c,
  output logic             o_cout,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_neg
);

  localparam int unsigned MAG_W = W - 1;

  logic [ACC_W-1:0] w_rnd;
  logic [ACC_W-1:0] w_s;
  logic [SAT_W-1:0] w_s_ext;
  logic [SAT_W:0]   w_sat;

`ifdef FXMUL_ROUND_EN
  // Half an output LSB; evaluates to zero when there are no fractional bits.
  localparam logic [ACC_W-1:0] RND_INC = (ACC_W'(1) << F) >> 1;
  assign w_rnd = i_acc + RND_INC;
`else
  assign w_rnd = i_acc;
`endif

  assign w_s        = w_rnd >> F;
  assign w_s_ext    = SAT_W'(w_s);
  assign w_sat      = sm_sat(w_s_ext, MAG_W);

  assign o_cout     = w_s[MAG_W];
  assign o_overflow = w_sat[SAT_W];
  assign o_zero     = (w_sat[SAT_W-1:0] == '0);
  assign o_neg      = i_sign & ~o_zero;
  assign o_c        = {o_neg, w_sat[MAG_W-1:0]};

endmodule

// File: rtl/fxmul_seq.sv
// Sequential shift-add sign-magnitude fixed-point multiplier with valid/ready handshakes.
// Define FXMUL_ROUND_EN to round half-up (adds one accumulator guard bit); default truncates.
module fxmul_seq
  import fxmul_pkg::*;
#(
  parameter int unsigned W = FXMUL_W_DEF,
  parameter int unsigned F = FXMUL_F_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         cout,
  output logic         zero,
  output logic         overflow,
  output logic         neg
);

  localparam int unsigned MAG_W = W - 1;
  localparam int unsigned CNT_W = $clog2(MAG_W + 1);
`ifdef FXMUL_ROUND_EN
  localparam int unsigned ACC_W = 2 * MAG_W + 1;
`else
  localparam int unsigned ACC_W = 2 * MAG_W;
`endif

  fxmul_state_t     r_state;
  logic             r_sign;
  logic [MAG_W-1:0] r_mag_a;
  logic [MAG_W-1:0] r_mag_b;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [W-1:0]     r_c;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_neg;

  logic [MAG_W-1:0] w_mag_a;
  logic [MAG_W-1:0] w_mag_b;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_last;
  logic [W-1:0]     w_n_c;
  logic             w_n_cout;
  logic             w_n_zero;
  logic             w_n_ovf;
  logic             w_n_neg;

  assign w_mag_a   = a[MAG_W-1:0];
  assign w_mag_b   = b[MAG_W-1:0];
  // r_mag_b is shifted right each iteration, so bit 0 is the current multiplier bit.
  assign w_acc_nxt = r_acc + (r_mag_b[0] ? (ACC_W'(r_mag_a) << r_cnt) : '0);
  assign w_last    = (r_cnt == CNT_W'(MAG_W - 1));

  // Fed with the post-add value so the last iteration and the DONE entry share one edge.
  fxmul_norm #(
    .W    (W),
    .F    (F),
    .ACC_W(ACC_W)
  ) u_norm (
    .i_sign    (r_sign),
    .i_acc     (w_acc_nxt),
    .o_c       (w_n_c),
    .o_cout    (w_n_cout),
    .o_zero    (w_n_zero),
    .o_overflow(w_n_ovf),
    .o_neg     (w_n_neg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign  <= a[W-1] ^ b[W-1];
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            if ((w_mag_a == '0) || (w_mag_b == '0)) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_c         <= '0;
              r_cout      <= 1'b0;
              r_zero      <= 1'b1;
              r_ovf       <= 1'b0;
              r_neg       <= 1'b0;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_acc   <= w_acc_nxt;
          r_mag_b <= r_mag_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_c         <= w_n_c;
            r_cout      <= w_n_cout;
            r_zero      <= w_n_zero;
            r_ovf       <= w_n_ovf;
            r_neg       <= w_n_neg;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign neg       = r_neg;

endmodule

// File: tb/tb_fxmul_seq.sv
// Self-checking bench for fxmul_seq: arithmetic reference model, per-cycle compare, directed cases
// plus randomized operands. Expectations follow FXMUL_ROUND_EN when it is defined.
module tb_fxmul_seq;

  typedef struct {
    logic [31:0] c;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        neg;
    int          vis;      // edges after the accept edge at which out_valid is first seen
    longint      acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a_i, b_i, c;
  logic        cout, zero, overflow, neg;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [23:0] a2, b2, c2;
  logic        cout2, zero2, overflow2, neg2;

  int     n_err = 0;
  int     n_chk = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint prev_acc = 0;
  bit     started = 0;
  bit     rst_seen = 0;
  exp_t   q[$];
  exp_t   mon_e;
  logic   exp_ov;

  fxmul_seq #(.W(16), .F(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .cout     (cout),
    .zero     (zero),
    .overflow (overflow),
    .neg      (neg)
  );

  fxmul_seq #(.W(24), .F(12)) u_dut24 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .a        (a2),
    .b        (b2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .c        (c2),
    .cout     (cout2),
    .zero     (zero2),
    .overflow (overflow2),
    .neg      (neg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Plain integer arithmetic on the sign-magnitude operands.
  function automatic exp_t model(input longint unsigned ta, input longint unsigned tb,
                                 input int w, input int f);
    exp_t            e;
    longint unsigned mask, ma, mb, p, s, mag;
    int              mw;
    mw   = w - 1;
    mask = (64'd1 << mw) - 64'd1;
    ma   = ta & mask;
    mb   = tb & mask;
    p    = ma * mb;
`ifdef FXMUL_ROUND_EN
    if (f > 0) p = p + (64'd1 << (f - 1));
`endif
    s      = p >> f;
    e.cout = ((s >> mw) & 64'd1) != 0;
    e.ovf  = s > mask;
    mag    = e.ovf ? mask : s;
    e.zero = (mag == 0);
    e.neg  = (((ta ^ tb) >> mw) & 64'd1) != 0 && !e.zero;
    e.c    = 32'(mag | (e.neg ? (64'd1 << mw) : 64'd0));
    e.vis  = (ma == 0 || mb == 0) ? 0 : mw;
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept/retire bookkeeping, sampled on the active edge before the DUT updates.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      rst_seen = 1;
      started  = 1;
    end else begin
      rst_seen = 0;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        mon_e = model(64'(a_i), 64'(b_i), 16, 8);
        mon_e.acc_cyc = cyc;
        q.push_back(mon_e);
        prev_acc = last_acc;
        last_acc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_cout", cout, 0);
        check("rst_zero", zero, 0);
        check("rst_overflow", overflow, 0);
        check("rst_neg", neg, 0);
        check("rst_in_ready", in_ready, rst_n);
      end else begin
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (cyc - q[0].acc_cyc) >= longint'(q[0].vis);
        check("in_ready", in_ready, rst_n && q.size() == 0);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov && out_valid === 1'b1) begin
          check("c", c, q[0].c);
          check("cout", cout, q[0].cout);
          check("zero", zero, q[0].zero);
          check("overflow", overflow, q[0].ovf);
          check("neg", neg, q[0].neg);
        end
      end
    end
  end

  // Issues one operation; k counts edges from the accept edge to the first visible out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input int bp,
                        output logic [15:0] rc, output logic [3:0] rf, output int k);
    int n;
    a_i = ta;
    b_i = tb;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin tick(); k++; end
    if (k >= 200) check("result_timeout", 0, 1);
    rc = c;
    rf = {cout, zero, overflow, neg};
    repeat (bp) tick();
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    exp_t        e;
    logic [15:0] rc, ra, rb;
    logic [3:0]  rf;
    int          k, n;
    bit          saw;

    rst_n = 1'b0;
    in_valid = 1'b0; a_i = '0; b_i = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b1;

    // Pin the model to hand-computed products.
    e = model(64'h0180, 64'h0200, 16, 8);
    check("model_1p5x2", e.c, 32'h0300);
    e = model(64'h7FFF, 64'h7FFF, 16, 8);
    check("model_sat_c", e.c, 32'h7FFF);
    check("model_sat_cout", e.cout, 1);
    e = model(64'h0001, 64'h0080, 16, 8);
`ifdef FXMUL_ROUND_EN
    check("model_underflow", e.c, 32'h0001);
`else
    check("model_underflow", e.c, 32'h0000);
`endif
    e = model(64'h001800, 64'h002000, 24, 12);
    check("model_w24", e.c, 32'h003000);

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1.5 * 2.0; 16 edges counting the accept edge itself
    run_op(16'h0180, 16'h0200, 0, rc, rf, k);
    check("c1_c", rc, 16'h0300);
    check("c1_flags", rf, 4'b0000);
    check("c1_latency", k, 15);

    run_op(16'h8180, 16'h0200, 0, rc, rf, k);
    check("c2_c", rc, 16'h8300);
    check("c2_neg", rf[0], 1);
    run_op(16'h8100, 16'h8100, 0, rc, rf, k);
    check("c2b_c", rc, 16'h0100);
    check("c2b_neg", rf[0], 0);

    run_op(16'h7FFF, 16'h7FFF, 0, rc, rf, k);
    check("c3_c", rc, 16'h7FFF);
    check("c3_ovf", rf[1], 1);
    check("c3_cout", rf[3], 1);
    run_op(16'hFFFF, 16'h7FFF, 0, rc, rf, k);
    check("c3b_c", rc, 16'hFFFF);
    check("c3b_ovf_neg", {rf[1], rf[0]}, 2'b11);

    run_op(16'h8000, 16'h1234, 0, rc, rf, k);
    check("c4_early_latency", k, 0);
    check("c4_c", rc, 16'h0000);
    check("c4_zero_neg", {rf[2], rf[0]}, 2'b10);
    run_op(16'h0001, 16'h0080, 0, rc, rf, k);
`ifdef FXMUL_ROUND_EN
    check("c4b_c", rc, 16'h0001);
    check("c4b_zero", rf[2], 0);
`else
    check("c4b_c", rc, 16'h0000);
    check("c4b_zero", rf[2], 1);
`endif

    // Backpressure: result held for 5 cycles, per-cycle compare covers stability.
    run_op(16'h0180, 16'h0200, 5, rc, rf, k);
    check("c5_c", rc, 16'h0300);

    // Back-to-back requests: the handshake cycle cannot accept.
    a_i = 16'h0180; b_i = 16'h0200; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    tick();
    a_i = 16'h0100; b_i = 16'h0200;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) check("bubble_timeout", 0, 1);
    check("bubble_c1", c, 16'h0300);
    tick();
    check("bubble_in_ready", in_ready, 1);
    check("bubble_out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("bubble_period", last_acc - prev_acc, 17);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    check("bubble_c2", c, 16'h0200);
    tick();

    // Reset during the seventh iteration aborts the operation.
    a_i = 16'h0180; b_i = 16'h0200; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin tick(); saw = saw | (out_valid === 1'b1); end
    check("c6_no_result", saw, 0);
    run_op(16'h0300, 16'h0080, 0, rc, rf, k);
    check("c6_fresh_c", rc, 16'h0180);

    // Wider configuration.
    a2 = 24'h001800; b2 = 24'h002000; in_valid2 = 1'b1;
    n = 0;
    while (in_ready2 !== 1'b1 && n < 200) begin tick(); n++; end
    tick();
    in_valid2 = 1'b0;
    k = 0;
    while (out_valid2 !== 1'b1 && k < 200) begin tick(); k++; end
    check("w24_latency", k, 23);
    check("w24_c", c2, 24'h003000);
    check("w24_flags", {cout2, zero2, overflow2, neg2}, 4'b0000);
    tick();
    check("w24_out_valid_drop", out_valid2, 0);

    // Random operands, occasional zero magnitudes and backpressure.
    repeat (150) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra[14:0] = '0;
      if ($urandom_range(0, 7) == 0) rb[14:0] = '0;
      run_op(ra, rb, $urandom_range(0, 3), rc, rf, k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
